rom_fetch_arbiter: RTL and testbench

//  Shares one external 16-bit ROM read port (SDRAM channel) between the M68K program ROM
//  (m68k_rom_cs, 0x000000-0x03ffff) and the Z80 sound ROM (z80_rom_cs, 0x0000-0xefff).

---
 rtl/rom_fetch_arbiter_pkg.sv | 36 +++
 rtl/rom_fetch_arbiter.sv | 254 +++++++++++++++++++++++++
 tb/tb_rom_fetch_arbiter.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_fetch_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rom_fetch_arbiter_pkg
// Description : Shared definitions for the ROM fetch arbiter: FSM state
//               encoding, grant identifiers, default external-memory base
//               addresses (also used by the SDRAM loader) and a big-endian
//               byte-select helper.
// Revision    : 1.0 - initial release
// ============================================================================
package rom_fetch_arbiter_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH_M = 2'd1,
        FETCH_Z = 2'd2
    } state_t;

    // Identifies which CPU owned the most recent memory grant
    typedef enum logic {
        GNT_M68K = 1'b0,
        GNT_Z80  = 1'b1
    } grant_t;

    // Default word addresses of the two ROM images in external memory
    localparam logic [23:0] C_M68K_BASE = 24'h000000;
    localparam logic [23:0] C_Z80_BASE  = 24'h020000;

    // Memory words are big-endian: the byte at even address sits in [15:8]
    function automatic logic [7:0] select_byte(input logic [15:0] word,
                                               input logic        a0);
        return a0 ? word[7:0] : word[15:8];
    endfunction

endpackage : rom_fetch_arbiter_pkg
`default_nettype wire

// File: rtl/rom_fetch_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rom_fetch_arbiter
// Description : Shares a single 16-bit external ROM read port between the
//               M68K program ROM and the Z80 sound ROM. Round-robin
//               arbitration, req/ack sequencing towards the SDRAM controller,
//               data return and CPU stalls (M68K DTACK_n, Z80 WAIT_n).
//               A one-word Z80 hit register serves the other byte of the most
//               recently fetched word without a memory access.
// Ports       :
//   clk           in   system clock
//   reset_n       in   asynchronous active-low reset
//   m68k_rom_cs   in   M68K ROM select, held for the bus cycle
//   m68k_a        in   M68K byte address (bits [17:1] used)
//   m68k_dout     out  ROM word to M68K
//   m68k_dtack_n  out  low = data valid, held until m68k_rom_cs drops
//   z80_rom_cs    in   Z80 ROM select
//   z80_addr      in   Z80 byte address
//   z80_dout      out  ROM byte to Z80
//   z80_wait_n    out  low = stall Z80 (combinational)
//   mem_req       out  read request, held until mem_ack
//   mem_addr      out  word address, stable while mem_req is high
//   mem_ack       in   one-cycle pulse, mem_data valid in the same cycle
//   mem_data      in   read data, big-endian
// Revision    : 1.0 - initial release
// ============================================================================
module rom_fetch_arbiter
    import rom_fetch_arbiter_pkg::*;
#(
    parameter int                ADDR_W    = 24,
    parameter logic [ADDR_W-1:0] M68K_BASE = ADDR_W'(C_M68K_BASE),
    parameter logic [ADDR_W-1:0] Z80_BASE  = ADDR_W'(C_Z80_BASE)
) (
    input  logic              clk,
    input  logic              reset_n,
    // M68K side
    input  logic              m68k_rom_cs,
    input  logic [23:0]       m68k_a,
    output logic [15:0]       m68k_dout,
    output logic              m68k_dtack_n,
    // Z80 side
    input  logic              z80_rom_cs,
    input  logic [15:0]       z80_addr,
    output logic [7:0]        z80_dout,
    output logic              z80_wait_n,
    // External memory port
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [15:0]       mem_data
);

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    state_t            r_state;
    state_t            w_state_nxt;
    grant_t            r_last_grant;

    logic              r_m68k_served;
    logic              r_z80_served;

    // Z80 request address captured at grant; CPU holds it, but the copy keeps
    // the hit tag independent of whatever the bus shows at ack time.
    logic [15:0]       r_z80_req_addr;

    logic              r_hit_valid;
    logic [14:0]       r_hit_addr;
    logic [15:0]       r_hit_data;

    logic              w_m68k_pend;
    logic              w_z80_pend;
    logic              w_z80_hit;
    logic              w_z80_elig;

    logic              w_grant_m;
    logic              w_grant_z;
    logic              w_hit_serve;
    logic              w_ack_m;
    logic              w_ack_z;

    logic [ADDR_W-1:0] w_m68k_addr;
    logic [ADDR_W-1:0] w_z80_addr;

    // Address bits outside the ROM window are intentionally ignored
    logic              w_unused;
    assign w_unused = ^{m68k_a[23:18], m68k_a[0]};

    // ------------------------------------------------------------------------
    // Pending requests, hit detection and address translation
    // ------------------------------------------------------------------------
    assign w_m68k_pend = m68k_rom_cs & ~r_m68k_served;
    assign w_z80_pend  = z80_rom_cs  & ~r_z80_served;

    assign w_z80_hit   = w_z80_pend & r_hit_valid &
                         (z80_addr[15:1] == r_hit_addr);

    // A Z80 access served from the hit register does not compete for memory
    assign w_z80_elig  = w_z80_pend & ~w_z80_hit;

    // Stall must assert in the same cycle the Z80 presents its request
    assign z80_wait_n  = ~w_z80_pend;

    assign w_m68k_addr = M68K_BASE + ADDR_W'(m68k_a[17:1]);
    assign w_z80_addr  = Z80_BASE  + ADDR_W'(z80_addr[15:1]);

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state and control strobes
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_grant_m   = 1'b0;
        w_grant_z   = 1'b0;
        w_hit_serve = 1'b0;
        w_ack_m     = 1'b0;
        w_ack_z     = 1'b0;

        case (r_state)
            IDLE: begin
                // Hit service only concerns the Z80; the M68K may still be
                // granted memory in the same cycle.
                w_hit_serve = w_z80_hit;

                if (w_m68k_pend && w_z80_elig) begin
                    // Tie: give it to whoever did not win last time
                    if (r_last_grant == GNT_Z80) begin
                        w_grant_m = 1'b1;
                    end else begin
                        w_grant_z = 1'b1;
                    end
                end else if (w_m68k_pend) begin
                    w_grant_m = 1'b1;
                end else if (w_z80_elig) begin
                    w_grant_z = 1'b1;
                end

                if (w_grant_m) begin
                    w_state_nxt = FETCH_M;
                end else if (w_grant_z) begin
                    w_state_nxt = FETCH_Z;
                end
            end

            FETCH_M: begin
                if (mem_ack) begin
                    w_ack_m     = 1'b1;
                    w_state_nxt = IDLE;
                end
            end

            FETCH_Z: begin
                if (mem_ack) begin
                    w_ack_z     = 1'b1;
                    w_state_nxt = IDLE;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Memory request port and arbitration history
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_req        <= 1'b0;
            mem_addr       <= '0;
            r_last_grant   <= GNT_Z80;
            r_z80_req_addr <= '0;
        end else begin
            if (w_grant_m) begin
                mem_req      <= 1'b1;
                mem_addr     <= w_m68k_addr;
                r_last_grant <= GNT_M68K;
            end else if (w_grant_z) begin
                mem_req        <= 1'b1;
                mem_addr       <= w_z80_addr;
                r_last_grant   <= GNT_Z80;
                r_z80_req_addr <= z80_addr;
            end else if (w_ack_m || w_ack_z) begin
                mem_req <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // M68K data return
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m68k_dout     <= '0;
            m68k_dtack_n  <= 1'b1;
            r_m68k_served <= 1'b0;
        end else begin
            if (!m68k_rom_cs) begin
                // Bus cycle over: release DTACK and re-arm for the next one
                m68k_dtack_n  <= 1'b1;
                r_m68k_served <= 1'b0;
            end else if (w_ack_m) begin
                m68k_dout     <= mem_data;
                m68k_dtack_n  <= 1'b0;
                r_m68k_served <= 1'b1;
            end
            // An ack arriving after the M68K abandoned its cycle is dropped
        end
    end

    // ------------------------------------------------------------------------
    // Z80 data return and hit register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            z80_dout     <= '0;
            r_z80_served <= 1'b0;
            r_hit_valid  <= 1'b0;
            r_hit_addr   <= '0;
            r_hit_data   <= '0;
        end else begin
            if (w_ack_z) begin
                // Fill the hit register even if the Z80 dropped its request;
                // the word is still good for the next access.
                r_hit_valid <= 1'b1;
                r_hit_addr  <= r_z80_req_addr[15:1];
                r_hit_data  <= mem_data;
            end

            if (!z80_rom_cs) begin
                r_z80_served <= 1'b0;
            end else if (w_hit_serve) begin
                z80_dout     <= select_byte(r_hit_data, z80_addr[0]);
                r_z80_served <= 1'b1;
            end else if (w_ack_z) begin
                z80_dout     <= select_byte(mem_data, r_z80_req_addr[0]);
                r_z80_served <= 1'b1;
            end
        end
    end

endmodule : rom_fetch_arbiter
`default_nettype wire

// File: tb/tb_rom_fetch_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rom_fetch_arbiter
// Description : Directed self-checking bench for rom_fetch_arbiter. A simple
//               memory responder acknowledges requests after a programmable
//               number of cycles with a test-chosen data word.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_fetch_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        m68k_rom_cs = 1'b0;
    logic [23:0] m68k_a = '0;
    logic [15:0] m68k_dout;
    logic        m68k_dtack_n;
    logic        z80_rom_cs = 1'b0;
    logic [15:0] z80_addr = '0;
    logic [7:0]  z80_dout;
    logic        z80_wait_n;
    logic        mem_req;
    logic [23:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_data = '0;

    int          total = 0;
    int          bad = 0;

    int          mem_lat = 3;
    logic [15:0] mem_word = '0;
    bit          auto_mem = 1'b1;
    int          lat_cnt = 0;
    int          req_cnt = 0;
    logic        req_q = 1'b0;

    always #5 clk = ~clk;

    rom_fetch_arbiter dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .m68k_rom_cs  (m68k_rom_cs),
        .m68k_a       (m68k_a),
        .m68k_dout    (m68k_dout),
        .m68k_dtack_n (m68k_dtack_n),
        .z80_rom_cs   (z80_rom_cs),
        .z80_addr     (z80_addr),
        .z80_dout     (z80_dout),
        .z80_wait_n   (z80_wait_n),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_data     (mem_data)
    );

    // Memory responder: ack after mem_lat cycles of mem_req being high
    always @(negedge clk) begin
        if (!auto_mem) begin
            lat_cnt = 0;
        end else if (mem_req === 1'b1 && !mem_ack) begin
            if (lat_cnt >= mem_lat - 1) begin
                mem_ack  = 1'b1;
                mem_data = mem_word;
                lat_cnt  = 0;
            end else begin
                lat_cnt++;
            end
        end else begin
            mem_ack = 1'b0;
            lat_cnt = 0;
        end
    end

    // Count new memory requests
    always @(negedge clk) begin
        if (mem_req === 1'b1 && req_q !== 1'b1) req_cnt++;
        req_q = mem_req;
    end

    task automatic apply_reset();
        @(negedge clk);
        reset_n     = 1'b0;
        m68k_rom_cs = 1'b0;
        z80_rom_cs  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        total++; if (mem_addr !== 24'h0) begin bad++; $display("FAIL reset_mem_addr: got %h want 000000", mem_addr); end
        total++; if (m68k_dout !== 16'h0) begin bad++; $display("FAIL reset_m68k_dout: got %h want 0000", m68k_dout); end
        total++; if (m68k_dtack_n !== 1'b1) begin bad++; $display("FAIL reset_dtack_n: got %b want 1", m68k_dtack_n); end
        total++; if (z80_dout !== 8'h0) begin bad++; $display("FAIL reset_z80_dout: got %h want 00", z80_dout); end
        total++; if (z80_wait_n !== 1'b1) begin bad++; $display("FAIL reset_z80_wait_n: got %b want 1", z80_wait_n); end
    endtask

    task automatic test_m68k_read();
        mem_lat  = 3;
        mem_word = 16'hBEEF;
        @(negedge clk);
        m68k_a      = 24'h000102;
        m68k_rom_cs = 1'b1;
        @(negedge clk);
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL m68k_req: got %b want 1", mem_req); end
        total++; if (mem_addr !== 24'h000081) begin bad++; $display("FAIL m68k_addr: got %h want 000081", mem_addr); end
        @(negedge clk);
        @(negedge clk);
        total++; if (m68k_dtack_n !== 1'b1) begin bad++; $display("FAIL m68k_dtack_early: got %b want 1", m68k_dtack_n); end
        @(negedge clk);
        total++; if (m68k_dtack_n !== 1'b0) begin bad++; $display("FAIL m68k_dtack: got %b want 0", m68k_dtack_n); end
        total++; if (m68k_dout !== 16'hBEEF) begin bad++; $display("FAIL m68k_dout: got %h want BEEF", m68k_dout); end
        @(negedge clk);
        total++; if (m68k_dtack_n !== 1'b0) begin bad++; $display("FAIL m68k_dtack_hold: got %b want 0", m68k_dtack_n); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL m68k_no_rereq: got %b want 0", mem_req); end
        m68k_rom_cs = 1'b0;
        @(negedge clk);
        total++; if (m68k_dtack_n !== 1'b1) begin bad++; $display("FAIL m68k_dtack_release: got %b want 1", m68k_dtack_n); end
    endtask

    task automatic test_round_robin();
        apply_reset();
        mem_lat     = 2;
        mem_word    = 16'h1122;
        m68k_a      = 24'h000200;
        z80_addr    = 16'h0010;
        m68k_rom_cs = 1'b1;
        z80_rom_cs  = 1'b1;
        #1;
        total++; if (z80_wait_n !== 1'b0) begin bad++; $display("FAIL rr_z80_stall: got %b want 0", z80_wait_n); end
        @(negedge clk);
        total++; if (mem_addr !== 24'h000100 || mem_req !== 1'b1) begin bad++; $display("FAIL rr1_first_m68k: got req=%b addr=%h want req=1 addr=000100", mem_req, mem_addr); end
        for (int i = 0; i < 12 && m68k_dtack_n !== 1'b0; i++) @(negedge clk);
        total++; if (m68k_dout !== 16'h1122 || m68k_dtack_n !== 1'b0) begin bad++; $display("FAIL rr1_m68k_data: got dtack=%b dout=%h want dtack=0 dout=1122", m68k_dtack_n, m68k_dout); end
        mem_word = 16'h3344;
        for (int i = 0; i < 12 && mem_req !== 1'b1; i++) @(negedge clk);
        total++; if (mem_addr !== 24'h020008 || mem_req !== 1'b1) begin bad++; $display("FAIL rr1_second_z80: got req=%b addr=%h want req=1 addr=020008", mem_req, mem_addr); end
        for (int i = 0; i < 12 && z80_wait_n !== 1'b1; i++) @(negedge clk);
        total++; if (z80_dout !== 8'h33 || z80_wait_n !== 1'b1) begin bad++; $display("FAIL rr1_z80_data: got wait_n=%b dout=%h want wait_n=1 dout=33", z80_wait_n, z80_dout); end
        m68k_rom_cs = 1'b0;
        z80_rom_cs  = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Lone M68K read: the most recent grant now belongs to the M68K
        mem_word    = 16'h5566;
        m68k_a      = 24'h000004;
        m68k_rom_cs = 1'b1;
        for (int i = 0; i < 12 && m68k_dtack_n !== 1'b0; i++) @(negedge clk);
        total++; if (m68k_dout !== 16'h5566 || m68k_dtack_n !== 1'b0) begin bad++; $display("FAIL rr_lone_m68k: got dtack=%b dout=%h want dtack=0 dout=5566", m68k_dtack_n, m68k_dout); end
        m68k_rom_cs = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Simultaneous pair again: Z80 must win this time
        mem_word    = 16'h7788;
        m68k_a      = 24'h000008;
        z80_addr    = 16'h0041;
        m68k_rom_cs = 1'b1;
        z80_rom_cs  = 1'b1;
        @(negedge clk);
        total++; if (mem_addr !== 24'h020020 || mem_req !== 1'b1) begin bad++; $display("FAIL rr2_first_z80: got req=%b addr=%h want req=1 addr=020020", mem_req, mem_addr); end
        for (int i = 0; i < 12 && z80_wait_n !== 1'b1; i++) @(negedge clk);
        total++; if (z80_dout !== 8'h88 || z80_wait_n !== 1'b1) begin bad++; $display("FAIL rr2_z80_data: got wait_n=%b dout=%h want wait_n=1 dout=88", z80_wait_n, z80_dout); end
        mem_word = 16'h99AA;
        for (int i = 0; i < 12 && m68k_dtack_n !== 1'b0; i++) @(negedge clk);
        total++; if (m68k_dout !== 16'h99AA || m68k_dtack_n !== 1'b0) begin bad++; $display("FAIL rr2_m68k_data: got dtack=%b dout=%h want dtack=0 dout=99AA", m68k_dtack_n, m68k_dout); end
        m68k_rom_cs = 1'b0;
        z80_rom_cs  = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_z80_hit();
        int req_before;
        mem_lat    = 2;
        mem_word   = 16'hA55A;
        z80_addr   = 16'h1234;
        z80_rom_cs = 1'b1;
        #1;
        total++; if (z80_wait_n !== 1'b0) begin bad++; $display("FAIL hit_miss_stall: got %b want 0", z80_wait_n); end
        for (int i = 0; i < 12 && mem_req !== 1'b1; i++) @(negedge clk);
        total++; if (mem_addr !== 24'h02091A || mem_req !== 1'b1) begin bad++; $display("FAIL hit_miss_addr: got req=%b addr=%h want req=1 addr=02091A", mem_req, mem_addr); end
        for (int i = 0; i < 12 && z80_wait_n !== 1'b1; i++) @(negedge clk);
        total++; if (z80_dout !== 8'hA5 || z80_wait_n !== 1'b1) begin bad++; $display("FAIL hit_first_byte: got wait_n=%b dout=%h want wait_n=1 dout=A5", z80_wait_n, z80_dout); end
        z80_rom_cs = 1'b0;
        @(negedge clk);
        req_before = req_cnt;
        z80_addr   = 16'h1235;
        z80_rom_cs = 1'b1;
        #1;
        total++; if (z80_wait_n !== 1'b0) begin bad++; $display("FAIL hit_stall: got %b want 0", z80_wait_n); end
        @(negedge clk);
        total++; if (z80_wait_n !== 1'b1) begin bad++; $display("FAIL hit_one_cycle: got wait_n=%b want 1", z80_wait_n); end
        total++; if (z80_dout !== 8'h5A) begin bad++; $display("FAIL hit_second_byte: got %h want 5A", z80_dout); end
        total++; if (mem_req !== 1'b0 || req_cnt != req_before) begin bad++; $display("FAIL hit_no_req: got req=%b new_reqs=%0d want req=0 new_reqs=0", mem_req, req_cnt - req_before); end
        z80_rom_cs = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_m68k_abort();
        mem_lat     = 4;
        mem_word    = 16'hDEAD;
        m68k_a      = 24'h000300;
        m68k_rom_cs = 1'b1;
        @(negedge clk);
        total++; if (mem_addr !== 24'h000180 || mem_req !== 1'b1) begin bad++; $display("FAIL abort_req: got req=%b addr=%h want req=1 addr=000180", mem_req, mem_addr); end
        m68k_rom_cs = 1'b0;
        for (int i = 0; i < 12 && mem_req !== 1'b0; i++) @(negedge clk);
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL abort_complete: got req=%b want 0", mem_req); end
        @(negedge clk);
        total++; if (m68k_dtack_n !== 1'b1) begin bad++; $display("FAIL abort_dtack: got %b want 1", m68k_dtack_n); end
        total++; if (m68k_dout === 16'hDEAD) begin bad++; $display("FAIL abort_discard: got %h want not DEAD", m68k_dout); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL abort_no_rereq: got %b want 0", mem_req); end
        mem_word    = 16'h1234;
        m68k_a      = 24'h000400;
        m68k_rom_cs = 1'b1;
        @(negedge clk);
        total++; if (mem_addr !== 24'h000200 || mem_req !== 1'b1) begin bad++; $display("FAIL abort_new_req: got req=%b addr=%h want req=1 addr=000200", mem_req, mem_addr); end
        for (int i = 0; i < 12 && m68k_dtack_n !== 1'b0; i++) @(negedge clk);
        total++; if (m68k_dout !== 16'h1234 || m68k_dtack_n !== 1'b0) begin bad++; $display("FAIL abort_new_data: got dtack=%b dout=%h want dtack=0 dout=1234", m68k_dtack_n, m68k_dout); end
        m68k_rom_cs = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_fetch();
        auto_mem = 1'b0;
        @(negedge clk);
        z80_addr   = 16'h0100;
        z80_rom_cs = 1'b1;
        @(negedge clk);
        total++; if (mem_addr !== 24'h020080 || mem_req !== 1'b1) begin bad++; $display("FAIL rst_mid_req: got req=%b addr=%h want req=1 addr=020080", mem_req, mem_addr); end
        #2;
        reset_n = 1'b0;
        #1;
        total++; if (mem_req !== 1'b0 || mem_addr !== 24'h0) begin bad++; $display("FAIL rst_mid_async: got req=%b addr=%h want req=0 addr=000000", mem_req, mem_addr); end
        z80_rom_cs = 1'b0;
        @(negedge clk);
        reset_n  = 1'b1;
        mem_ack  = 1'b1;
        mem_data = 16'hFFFF;
        @(negedge clk);
        mem_ack = 1'b0;
        total++; if (mem_req !== 1'b0 || z80_dout !== 8'h00 || m68k_dtack_n !== 1'b1) begin bad++; $display("FAIL rst_stray_ack: got req=%b z80_dout=%h dtack=%b want req=0 z80_dout=00 dtack=1", mem_req, z80_dout, m68k_dtack_n); end
        auto_mem   = 1'b1;
        mem_lat    = 2;
        mem_word   = 16'hC3D2;
        z80_addr   = 16'h1234;
        z80_rom_cs = 1'b1;
        for (int i = 0; i < 12 && mem_req !== 1'b1; i++) @(negedge clk);
        total++; if (mem_addr !== 24'h02091A || mem_req !== 1'b1) begin bad++; $display("FAIL rst_refetch: got req=%b addr=%h want req=1 addr=02091A", mem_req, mem_addr); end
        for (int i = 0; i < 12 && z80_wait_n !== 1'b1; i++) @(negedge clk);
        total++; if (z80_dout !== 8'hC3 || z80_wait_n !== 1'b1) begin bad++; $display("FAIL rst_refetch_data: got wait_n=%b dout=%h want wait_n=1 dout=C3", z80_wait_n, z80_dout); end
        z80_rom_cs = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_m68k_read();
        test_round_robin();
        test_z80_hit();
        test_m68k_abort();
        test_reset_mid_fetch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_rom_fetch_arbiter
`default_nettype wire
